// File: rtl/h_feed_pkg.sv
// Shared types and constants for the H stream feeder.
// The element counter is laid out as {q, i[1:0], j, k[1:0]}, with k in the LSBs.
package h_feed_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam int NUM_ELEM   = 16;
    localparam int NUM_Q_DEF  = 16;
    localparam int STREAM_LEN = NUM_Q_DEF * 32;

    // Bit offsets of the fields inside the element counter
    localparam int K_LSB = 0;
    localparam int J_LSB = 2;
    localparam int I_LSB = 3;
    localparam int Q_LSB = 5;

    // The bank read address is {row i, column k}; j and q only repeat the pass
    function automatic logic [3:0] elem_addr(input logic [4:0] low);
        return {low[I_LSB +: 2], low[K_LSB +: 2]};
    endfunction
endpackage

// File: rtl/h_bank_ram.sv
// 16-entry register file holding one H matrix, packed as {real, imag}.
// It has one synchronous write port and one asynchronous read port.
// The contents are not reset, so a bank holds no valid data until it is filled.
module h_bank_ram
    import h_feed_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         we,
    input  logic [3:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [3:0]   raddr,
    output logic [W-1:0] rdata
);
    logic [W-1:0] mem [NUM_ELEM];

    // Write a word on the clock edge
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/h_stream_feeder.sv
// This block loads one 4x4 complex H matrix and replays it to the Hq multiplier.
// For each q it walks i, j and k and emits H[i][k] once per cycle.
// Define DOUBLE_BUFFER_EN to get a second bank.
// With it, the next H can be loaded while the current one streams out.
module h_stream_feeder
    import h_feed_pkg::*;
#(
    parameter int N     = 16,
    parameter int NUM_Q = NUM_Q_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         h_wr_valid,
    output logic         h_wr_ready,
    input  logic [N-1:0] h_wr_r,
    input  logic [N-1:0] h_wr_i,
    input  logic         go,
    input  logic         hq_all_done,
    output logic         mm_start,
    output logic [N-1:0] h_out_r,
    output logic [N-1:0] h_out_i,
    output logic         h_out_valid,
    output logic         busy,
    output logic         replay_done
);
`ifdef DOUBLE_BUFFER_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam int CW = QW + Q_LSB;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [NB-1:0]   bank_full;
    logic            wb, rb;
    logic [3:0]      wptr;
    logic [2*N-1:0]  rdata [NB];
    logic [2*N-1:0]  rd_word;
    logic [3:0]      rd_addr;
    logic            wr_fire, wr_last, rel_bank, last_elem;
    logic            start_d, done_d;

    assign h_wr_ready = !bank_full[wb];
    assign wr_fire    = h_wr_valid && h_wr_ready;
    assign wr_last    = wr_fire && (wptr == 4'(NUM_ELEM - 1));
    assign rel_bank   = (state_q == WAIT) && hq_all_done;
    assign rd_addr    = elem_addr(cnt_q[4:0]);
    assign rd_word    = rdata[rb];
    assign last_elem  = (cnt_q[CW-1:Q_LSB] == QW'(NUM_Q - 1)) && (cnt_q[I_LSB +: 2] == 2'd3)
                      && cnt_q[J_LSB] && (cnt_q[K_LSB +: 2] == 2'd3);
    assign busy       = (state_q != IDLE);

    for (genvar b = 0; b < NB; b++) begin : g_bank
        h_bank_ram #(.W(2*N)) u_bank (
            .clk   (clk),
            .we    (wr_fire && (wb == 1'(b))),
            .waddr (wptr),
            .wdata ({h_wr_r, h_wr_i}),
            .raddr (rd_addr),
            .rdata (rdata[b])
        );
    end

    // Write pointer. Load and replay pointers toggle only when two banks exist.
`ifdef DOUBLE_BUFFER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            wb   <= 1'b0;
            rb   <= 1'b0;
        end else begin
            if (wr_fire)  wptr <= wptr + 4'd1;
            if (wr_last)  wb   <= ~wb;
            if (rel_bank) rb   <= ~rb;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          wptr <= '0;
        else if (wr_fire) wptr <= wptr + 4'd1;
    end
    assign wb = 1'b0;
    assign rb = 1'b0;
`endif

    // A full flag is set by the 16th write into its bank.
    // It clears when the multiplier releases the bank being replayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (wr_last && (wb == 1'(b)))  bank_full[b] <= 1'b1;
                if (rel_bank && (rb == 1'(b))) bank_full[b] <= 1'b0;
            end
        end
    end

    // Replay FSM state register and element counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == STREAM) ? cnt_q + CW'(1) : '0;
        end
    end

    // Next-state logic; go is honoured only in IDLE and only when the bank is full
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE:    if (go && bank_full[rb]) begin state_d = STREAM; start_d = 1'b1; end
            STREAM:  if (last_elem) state_d = WAIT;
            WAIT:    if (hq_all_done) begin state_d = IDLE; done_d = 1'b1; end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs. h_out lags the counter by one cycle, so element 0 follows mm_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_start    <= 1'b0;
            replay_done <= 1'b0;
            h_out_valid <= 1'b0;
            h_out_r     <= '0;
            h_out_i     <= '0;
        end else begin
            mm_start    <= start_d;
            replay_done <= done_d;
            h_out_valid <= (state_q == STREAM);
            if (state_q == STREAM) begin
                h_out_r <= rd_word[2*N-1:N];
                h_out_i <= rd_word[N-1:0];
            end else begin
                h_out_r <= '0;
                h_out_i <= '0;
            end
        end
    end
endmodule

// File: tb/tb_h_stream_feeder.sv
// Directed bench for h_stream_feeder. Build it with or without DOUBLE_BUFFER_EN.
module tb_h_stream_feeder;
    logic        clk = 1'b0;
    logic        rst;
    logic        h_wr_valid, go, hq_all_done;
    logic [15:0] h_wr_r, h_wr_i;
    logic        h_wr_ready, mm_start, h_out_valid, busy, replay_done;
    logic [15:0] h_out_r, h_out_i;
    int          n_cmp = 0;
    int          n_bad = 0;

    h_stream_feeder #(.N(16), .NUM_Q(16)) dut (
        .clk(clk), .rst(rst),
        .h_wr_valid(h_wr_valid), .h_wr_ready(h_wr_ready),
        .h_wr_r(h_wr_r), .h_wr_i(h_wr_i),
        .go(go), .hq_all_done(hq_all_done),
        .mm_start(mm_start), .h_out_r(h_out_r), .h_out_i(h_out_i),
        .h_out_valid(h_out_valid), .busy(busy), .replay_done(replay_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write ramp words H = (w, -w) for w = from..to
    task automatic load_range(input int from, input int to);
        for (int w = from; w <= to; w++) begin
            h_wr_valid = 1'b1;
            h_wr_r = 16'(w);
            h_wr_i = 16'(-w);
            tick();
        end
        h_wr_valid = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    // Called in the mm_start cycle. It checks elements 0..stop_at, or the full 512 if stop_at < 0.
    task automatic run_stream(input bit konst, input int done_at, input bit load_b, input int stop_at);
        int last, bad, rdy_bad, v, first_n;
        logic [15:0] er, ei, first_r;
        last = (stop_at >= 0) ? stop_at : 511;
        bad = 0; rdy_bad = 0; first_n = -1; first_r = '0;
        for (int n = 0; n <= last; n++) begin
            if (load_b && n >= 10 && n < 26) begin
                h_wr_valid = 1'b1; h_wr_r = 16'd7; h_wr_i = 16'd7;
                if (h_wr_ready !== 1'b1) rdy_bad++;
            end else begin
                h_wr_valid = 1'b0;
            end
            hq_all_done = (n == done_at);
            tick();
            v  = konst ? 7 : (((n >> 3) & 3) * 4 + (n & 3));
            er = 16'(v);
            ei = konst ? 16'd7 : 16'(-v);
            if (h_out_valid !== 1'b1 || h_out_r !== er || h_out_i !== ei) begin
                if (first_n < 0) begin first_n = n; first_r = h_out_r; end
                bad++;
            end
            if (n == 0 || n == 8 || n == 511) begin
                n_cmp++;
                if (h_out_r !== er || h_out_i !== ei || h_out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL elem%0d: got (%0d,%0d) v=%b, want (%0d,%0d) v=1", n,
                             $signed(h_out_r), $signed(h_out_i), h_out_valid, $signed(er), $signed(ei));
                end
            end
            if (n == 1) begin
                n_cmp++;
                if (mm_start !== 1'b0) begin n_bad++; $display("FAIL mm_start_width: got %b want 0", mm_start); end
            end
`ifndef DOUBLE_BUFFER_EN
            if (n == 256) begin
                n_cmp++;
                if (h_wr_ready !== 1'b0) begin n_bad++; $display("FAIL ready_in_stream: got %b want 0", h_wr_ready); end
            end
`endif
        end
        h_wr_valid = 1'b0;
        hq_all_done = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL stream_data: %0d bad elements, first n=%0d got r=%0d, want 0 bad", bad, first_n, $signed(first_r));
        end
        if (load_b) begin
            n_cmp++;
            if (rdy_bad != 0) begin n_bad++; $display("FAIL ready_dbuf: %0d low cycles, want 0", rdy_bad); end
        end
        if (last == 511) begin
            tick();
            n_cmp++;
            if (h_out_valid !== 1'b0 || h_out_r !== 16'd0 || h_out_i !== 16'd0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL post_stream: got v=%b r=%0d i=%0d busy=%b, want v=0 r=0 i=0 busy=1",
                         h_out_valid, h_out_r, h_out_i, busy);
            end
        end
    endtask

    // Called in the first WAIT cycle. It waits `delay` cycles and then releases the bank.
    task automatic finish_replay(input int delay);
        repeat (delay) tick();
        n_cmp++;
        if (busy !== 1'b1 || replay_done !== 1'b0) begin
            n_bad++; $display("FAIL wait_state: got busy=%b done=%b, want busy=1 done=0", busy, replay_done);
        end
        hq_all_done = 1'b1;
        tick();
        hq_all_done = 1'b0;
        n_cmp++;
        if (replay_done !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL replay_done: got done=%b busy=%b, want done=1 busy=0", replay_done, busy);
        end
`ifndef DOUBLE_BUFFER_EN
        n_cmp++;
        if (h_wr_ready !== 1'b1) begin n_bad++; $display("FAIL ready_release: got %b want 1", h_wr_ready); end
`endif
        tick();
        n_cmp++;
        if (replay_done !== 1'b0) begin n_bad++; $display("FAIL done_width: got %b want 0", replay_done); end
    endtask

    task automatic test_reset();
        rst = 1'b1; h_wr_valid = 1'b0; go = 1'b0; hq_all_done = 1'b0; h_wr_r = '0; h_wr_i = '0;
        #3;
        n_cmp++;
        if (mm_start !== 1'b0 || h_out_r !== 16'd0 || h_out_i !== 16'd0 || h_out_valid !== 1'b0 ||
            busy !== 1'b0 || replay_done !== 1'b0 || h_wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset: got st=%b r=%0d i=%0d v=%b busy=%b done=%b rdy=%b, want 0 0 0 0 0 0 1",
                     mm_start, h_out_r, h_out_i, h_out_valid, busy, replay_done, h_wr_ready);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_underfill();
        load_range(0, 14);
        pulse_go();
        n_cmp++;
        if (mm_start !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL go_not_full: got start=%b busy=%b, want 0 0", mm_start, busy);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL go_not_queued: got busy=%b want 0", busy); end
        load_range(15, 15);
`ifndef DOUBLE_BUFFER_EN
        n_cmp++;
        if (h_wr_ready !== 1'b0) begin n_bad++; $display("FAIL ready_full: got %b want 0", h_wr_ready); end
`endif
        pulse_go();
        n_cmp++;
        if (mm_start !== 1'b1 || busy !== 1'b1 || h_out_valid !== 1'b0) begin
            n_bad++; $display("FAIL start: got start=%b busy=%b v=%b, want 1 1 0", mm_start, busy, h_out_valid);
        end
        run_stream(1'b0, 100, 1'b0, -1);
        finish_replay(10);
    endtask

    task automatic test_same_cycle();
        load_range(0, 14);
        h_wr_valid = 1'b1; h_wr_r = 16'd15; h_wr_i = 16'(-15); go = 1'b1;
        tick();
        h_wr_valid = 1'b0;
        n_cmp++;
        if (mm_start !== 1'b0) begin n_bad++; $display("FAIL same_cycle_go: got start=%b want 0", mm_start); end
        tick();
        go = 1'b0;
        n_cmp++;
        if (mm_start !== 1'b1) begin n_bad++; $display("FAIL held_go: got start=%b want 1", mm_start); end
        run_stream(1'b0, -1, 1'b0, -1);
        finish_replay(3);
    endtask

`ifdef DOUBLE_BUFFER_EN
    task automatic test_double_buffer();
        load_range(0, 15);
        pulse_go();
        n_cmp++;
        if (mm_start !== 1'b1) begin n_bad++; $display("FAIL dbuf_start_a: got %b want 1", mm_start); end
        run_stream(1'b0, -1, 1'b1, -1);
        finish_replay(2);
        pulse_go();
        n_cmp++;
        if (mm_start !== 1'b1) begin n_bad++; $display("FAIL dbuf_start_b: got %b want 1", mm_start); end
        run_stream(1'b1, -1, 1'b0, -1);
        finish_replay(2);
    endtask
`endif

    task automatic test_mid_reset();
        load_range(0, 15);
        pulse_go();
        run_stream(1'b0, -1, 1'b0, 200);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mm_start !== 1'b0 || h_out_r !== 16'd0 || h_out_i !== 16'd0 || h_out_valid !== 1'b0 ||
            busy !== 1'b0 || replay_done !== 1'b0 || h_wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset: got st=%b r=%0d i=%0d v=%b busy=%b done=%b rdy=%b, want 0 0 0 0 0 0 1",
                     mm_start, h_out_r, h_out_i, h_out_valid, busy, replay_done, h_wr_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        load_range(0, 15);
        pulse_go();
        n_cmp++;
        if (mm_start !== 1'b1) begin n_bad++; $display("FAIL restart: got %b want 1", mm_start); end
        run_stream(1'b0, -1, 1'b0, -1);
        finish_replay(1);
    endtask

    initial begin
        test_reset();
        test_underfill();
        test_same_cycle();
`ifdef DOUBLE_BUFFER_EN
        test_double_buffer();
`endif
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/h_stream_feeder.md
# h_stream_feeder

Source side of the Hq matrix multiplier's H input. Accepts one 4x4 complex channel matrix H (row-major, 16 complex words) over a valid/ready write port, then replays it in the multiplier's consumption order: q = 0..15, row i = 0..3, column j = 0..1, element k = 0..3, emitting H[i][k] every cycle. It issues the multiplier's one-cycle start and holds off the next matrix until the multiplier reports all 16 Hq products done.

## Interface
Parameters:
- N, 16, bit width of each real/imag component (signed, Q-format unchanged, pass-through).
- NUM_Q, 16, number of S matrices per H replay (q counter range 0..NUM_Q-1).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; asynchronous, active-high.
- h_wr_valid, in, 1, write word present.
- h_wr_ready, out, 1, write word accepted when valid && ready.
- h_wr_r, in, N, signed real part of H element.
- h_wr_i, in, N, signed imag part of H element.
- go, in, 1, request to start a replay (pulse or level).
- hq_all_done, in, 1, multiplier all_16_hq_done.
- mm_start, out, 1, one-cycle start pulse to the multiplier.
- h_out_r, out, N, H element real to the multiplier.
- h_out_i, out, N, H element imag to the multiplier.
- h_out_valid, out, 1, h_out carries a stream element.
- busy, out, 1, high in STREAM and WAIT.
- replay_done, out, 1, one-cycle pulse on WAIT -> IDLE.

## Operation
- Write port: 4-bit write pointer, address = row*4 + col. ready = !bank_full[wb]. The 16th accepted word sets bank_full[wb] and wraps the pointer to 0. Writes are independent of the FSM state.
- FSM states:
  - IDLE -> STREAM when go && bank_full[rb]. mm_start pulses in that transition cycle.
  - STREAM: 9-bit element counter {q[3:0], i[1:0], j, k[1:0]}. Read address = {i,k}. STREAM -> WAIT after element 511, i.e. q=NUM_Q-1, i=3, j=1, k=3.
  - WAIT -> IDLE on hq_all_done. In that transition bank_full[rb] clears, rb advances, and replay_done pulses.
- hq_all_done outside WAIT is ignored. go outside IDLE is ignored. go in IDLE with the bank not full is ignored; it is not queued.
- Simultaneous events: a write that completes the bank in the same cycle as go does not start the replay, because go sees the registered full flag; go must be held or re-pulsed. A write and a bank clear on the same bank in the same cycle cannot occur because the banks are distinct; in single-bank mode, ready is low while full, so this case also cannot occur.
- Outputs outside STREAM: h_out_r and h_out_i = 0, h_out_valid = 0.
- Reset mid-operation: all state returns to reset values immediately. Bank contents are don't-care. Both full flags and both pointers clear.

## Timing
- Reset values: mm_start 0, h_out_r 0, h_out_i 0, h_out_valid 0, busy 0, replay_done 0. h_wr_ready = 1, combinational from the cleared full flags.
- Cycle T: go accepted and mm_start = 1.
- Cycle T+1: H[0][0] on h_out with h_out_valid = 1. This matches the multiplier's cal_en rising at T+1 with its counters at 0.
- Cycles T+1 .. T+512: one element per cycle with no gaps; h_out_valid is high for exactly 512 cycles. Element n uses row = n[4:3] and col = n[1:0].
- h_out, h_out_valid, mm_start and replay_done are registered; no combinational path from inputs to these outputs.
- Write acceptance has zero-cycle latency; ready deasserts in the cycle after the 16th accept.
- Earliest restart: go can be accepted in the cycle after replay_done.

## Configuration
- DOUBLE_BUFFER_EN defined: two banks. wb and rb each toggle independently, so the next H can be written while the current one streams, and back-to-back replays are separated only by WAIT.
- DOUBLE_BUFFER_EN undefined: one bank, wb = rb = 0. ready stays low from the 16th write until replay_done, so no loading is possible during STREAM or WAIT.

## Structure
- Shared package h_feed_pkg holds:
  - state enum {IDLE, STREAM, WAIT};
  - localparams NUM_ELEM = 16, STREAM_LEN = NUM_Q*32 (512);
  - field offsets of the element counter.
- One sub-module, h_bank_ram: 16-entry x 2N register file, one synchronous write port, one asynchronous read port, instantiated once per bank. The read-side output register stays in h_stream_feeder.

## Test plan
- Load H[r][c] = (r*4+c, -(r*4+c)), then pulse go -> mm_start for 1 cycle. Next cycle h_out = (0,0). Elements 0..7 = (0,0),(1,-1),(2,-2),(3,-3),(0,0),(1,-1),(2,-2),(3,-3). Element 8 = (4,-4). Element 511 = (15,-15). h_out_valid high exactly 512 cycles, then h_out returns to 0.
- Pulse go with only 15 words written -> no mm_start and busy stays 0. The 16th write plus go the next cycle -> replay starts.
- 16th write and go in the same cycle -> no start that cycle. go held one more cycle -> mm_start.
- hq_all_done pulsed during STREAM -> ignored and streaming continues. Pulsed 10 cycles into WAIT -> replay_done 1 cycle later and busy = 0.
- With DOUBLE_BUFFER_EN, load H_B (all (7,7)) during the H_A replay -> ready high throughout. After replay_done, go -> stream of (7,7). Without the macro, h_wr_ready = 0 from the 16th write until replay_done.
- Assert rst at element 200 -> all outputs at reset values immediately and h_wr_ready = 1. A reload plus go -> a clean stream starting from H[0][0].
